// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver with word packing and an output FIFO.
//
// The serial line is synchronized, a start edge is qualified at mid-bit, and
// 8 data bits are sampled LSB first. BYTE_WIDTH bytes are packed into one
// word, in little- or big-endian order. Each complete word is written into a
// synchronous-read RAM FIFO. Words are presented on rdata with a
// valid/ready handshake.
//
// Optional feature macro: UART_RX_FRAME_CHECK_EN
//   defined   : a stop bit sampled low drops the byte and the partial word
//               and pulses o_frame_err. The receiver then waits for the line
//               to return high, so a break reports only once.
//   undefined : the stop bit is ignored, and o_frame_err is tied low.
//
// Ports
//   clk         in   sole clock
//   rst_n       in   asynchronous active-low reset
//   i_uart_rx   in   serial line (async, idle high)
//   rvalid      out  rdata holds a FIFO word
//   rready      in   consumer accepts rdata
//   rdata       out  BYTE_WIDTH*8-bit word
//   o_overflow  out  1-cycle pulse: word dropped, FIFO full
//   o_frame_err out  1-cycle pulse: bad stop bit (frame check build only)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int UART_CLK_DIV = 434,
    parameter int FIFO_ASIZE   = 9,
    parameter int BYTE_WIDTH   = 1,
    parameter int BIG_ENDIAN   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_uart_rx,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [BYTE_WIDTH*8-1:0] rdata,
    output logic                    o_overflow,
    output logic                    o_frame_err
);

    localparam int CW    = $clog2(UART_CLK_DIV);
    localparam int AW    = FIFO_ASIZE;
    localparam int DW    = BYTE_WIDTH * 8;
    localparam int BCW   = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam int DEPTH = 1 << FIFO_ASIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer and start-edge qualification
    // ------------------------------------------------------------------
    logic       r_sync1, r_sync2;
    logic [1:0] r_warm;     // marks when r_sync2 holds a real post-reset sample
    logic       r_prev_hi;  // previous synchronized sample was a real '1'

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_warm    <= 2'b00;
            r_prev_hi <= 1'b0;
        end else begin
            r_sync1   <= i_uart_rx;
            r_sync2   <= r_sync1;
            r_warm    <= {r_warm[0], 1'b1};
            // The flops' reset value of 1 is not a real sample. Until real
            // samples arrive, no 1->0 edge can be seen. So a line that is
            // already low at reset release is never taken as a start bit.
            r_prev_hi <= r_warm[1] & r_sync2;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            w_tick;
    logic            w_start;
    logic            w_brk;
    logic            w_stop_smp;

    assign w_tick  = (r_cnt == '0);
    assign w_start = (r_state == IDLE) & r_prev_hi & ~r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:  if (w_start) w_state_nx = START;
            START: if (w_tick)  w_state_nx = r_sync2 ? IDLE : DATA;
            DATA:  if (w_tick && (r_bit == 3'd7)) w_state_nx = STOP;
            STOP: begin
`ifdef UART_RX_FRAME_CHECK_EN
                if (w_brk) begin
                    if (r_sync2) w_state_nx = IDLE;
                end else if (w_tick) begin
                    w_state_nx = r_sync2 ? IDLE : STOP;
                end
`else
                if (w_tick) w_state_nx = IDLE;
`endif
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) r_cnt <= CW'(UART_CLK_DIV/2 - 1);
                START: begin
                    if (w_tick) begin
                        r_cnt <= CW'(UART_CLK_DIV - 1);
                        r_bit <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        r_cnt   <= CW'(UART_CLK_DIV - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                STOP: if (!w_tick) r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= '0;
            endcase
        end
    end

    // The stop-bit sample point. While waiting out a break, the counter
    // rests at zero, so w_brk masks the repeated tick.
    assign w_stop_smp = (r_state == STOP) & w_tick & ~w_brk;

    // ------------------------------------------------------------------
    // Frame check
    // ------------------------------------------------------------------
    logic w_byte_ok;
`ifdef UART_RX_FRAME_CHECK_EN
    logic r_brk, r_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brk  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ferr <= w_stop_smp & ~r_sync2;
            if (w_stop_smp && !r_sync2) r_brk <= 1'b1;
            else if (r_brk && r_sync2)  r_brk <= 1'b0;
        end
    end

    assign w_brk       = r_brk;
    assign w_byte_ok   = r_sync2;
    assign o_frame_err = r_ferr;
`else
    assign w_brk       = 1'b0;
    assign w_byte_ok   = 1'b1;
    assign o_frame_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Word packing
    // ------------------------------------------------------------------
    logic [DW-1:0]  r_word, w_word_nx, r_push_data;
    logic [BCW-1:0] r_bcnt;
    logic           r_push;

    always_comb begin
        w_word_nx = r_word;
        for (int k = 0; k < BYTE_WIDTH; k++) begin
            if (r_bcnt == BCW'(k)) begin
                if (BIG_ENDIAN != 0) w_word_nx[(BYTE_WIDTH-1-k)*8 +: 8] = r_shift;
                else                 w_word_nx[k*8 +: 8]                = r_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word      <= '0;
            r_bcnt      <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_stop_smp) begin
                if (!w_byte_ok) begin
                    r_word <= '0;
                    r_bcnt <= '0;
                end else if (r_bcnt == BCW'(BYTE_WIDTH - 1)) begin
                    r_push      <= 1'b1;
                    r_push_data <= w_word_nx;
                    r_word      <= '0;
                    r_bcnt      <= '0;
                end else begin
                    r_word <= w_word_nx;
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO: the RAM plus a one-word output register.
    // r_rd_ptr advances on pop, so the word held on rdata still counts
    // toward occupancy. r_pf_ptr is the prefetch read address.
    // ------------------------------------------------------------------
    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [DW-1:0] r_ram_q;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_pf_ptr;
    logic          r_pend;
    logic          r_ovalid;
    logic [DW-1:0] r_odata;
    logic          r_ovf;
    logic          w_full, w_wr, w_pop, w_issue;

    assign w_full  = ((r_wr_ptr + AW'(1)) == r_rd_ptr);
    assign w_wr    = r_push & ~w_full;
    assign w_pop   = r_ovalid & rready;
    assign w_issue = (r_pf_ptr != r_wr_ptr) & ~r_pend & (~r_ovalid | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr)    r_mem[r_wr_ptr] <= r_push_data;
        if (w_issue) r_ram_q         <= r_mem[r_pf_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_pf_ptr <= '0;
            r_pend   <= 1'b0;
            r_ovalid <= 1'b0;
            r_odata  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf  <= r_push & w_full;
            r_pend <= w_issue;
            if (w_wr)    r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_issue) r_pf_ptr <= r_pf_ptr + AW'(1);
            // A prefetch is issued only when the output register will be
            // free, so loading here never overwrites a word that is still
            // being presented.
            if (r_pend) begin
                r_odata  <= r_ram_q;
                r_ovalid <= 1'b1;
            end else if (w_pop) begin
                r_ovalid <= 1'b0;
            end
        end
    end

    assign rvalid     = r_ovalid;
    assign rdata      = r_odata;
    assign o_overflow = r_ovf;

endmodule
